// File: rtl/i2c_uart_pkg.sv
// Shared definitions for the I2C sniffer event path: tag codes, ASCII
// constants and the frame byte formatter used by the UART scheduler.
package i2c_uart_pkg;

  localparam logic [1:0] TAG_A = 2'd0;
  localparam logic [1:0] TAG_R = 2'd1;
  localparam logic [1:0] TAG_D = 2'd2;

  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_A     = 8'h41;
  localparam logic [7:0] ASCII_R     = 8'h52;
  localparam logic [7:0] ASCII_D     = 8'h44;

  localparam int FRAME_LEN = 5;
  localparam int ENTRY_W   = 10;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_SEND      = 2'd2,
    ST_WAIT_DONE = 2'd3
  } tx_state_e;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    logic [7:0] wide;
    wide = {4'h0, nib};
    if (wide < 8'd10) begin
      return 8'h30 + wide;
    end else begin
      return 8'h37 + wide;
    end
  endfunction

  function automatic logic [7:0] tag_to_ascii(input logic [1:0] tag);
    logic [7:0] c;
    case (tag)
      TAG_A:   c = ASCII_A;
      TAG_R:   c = ASCII_R;
      TAG_D:   c = ASCII_D;
      default: c = 8'h3F;
    endcase
    return c;
  endfunction

  // Byte idx of the 5-byte frame "<tag>:<hi><lo><sep>" for one queue entry.
  function automatic logic [7:0] frame_byte(input logic [ENTRY_W-1:0] entry,
                                            input logic [2:0]         idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = tag_to_ascii(entry[9:8]);
      3'd1:    b = ASCII_COLON;
      3'd2:    b = nibble_to_ascii(entry[7:4]);
      3'd3:    b = nibble_to_ascii(entry[3:0]);
      3'd4:    b = (entry[9:8] == TAG_D) ? ASCII_LF : ASCII_SPACE;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Synchronous event queue with occupancy count; push is accepted when full
// only if a pop happens in the same cycle.
module event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT   = (AW+1)'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      level_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign empty     = (level_r == '0);
  assign full      = (level_r == DEPTH_CNT);
  assign level     = level_r;
  assign pop_data  = mem_r[rd_ptr_r];
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);

  // Storage array; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + ONE_CNT;
        2'b01:   level_r <= level_r - ONE_CNT;
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/i2c_event_tx_scheduler.sv
// Queues sniffed I2C address/register/data events and serialises each one
// to the UART transmitter as a 5-byte ASCII frame.
module i2c_event_tx_scheduler
  import i2c_uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         address_ready,
  input  logic                         reg_address_ready,
  input  logic                         reg_data_ready,
  input  logic [7:0]                   address,
  input  logic [7:0]                   reg_address,
  input  logic [7:0]                   reg_data,
  output logic [7:0]                   uart_tx_data,
  output logic                         uart_tx_en,
  input  logic                         uart_tx_done,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic [7:0]                   drop_cnt,
  output logic                         overflow
);

  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

  tx_state_e          state_r, state_s;
  logic [ENTRY_W-1:0] frame_r, frame_s;
  logic [2:0]         byte_idx_r, byte_idx_s;
  logic [7:0]         tx_data_r, tx_data_s;
  logic               tx_en_r, tx_en_s;
  logic [7:0]         drop_cnt_r;
  logic               overflow_r;

  logic               push_req_s;
  logic [ENTRY_W-1:0] push_entry_s;
  logic [1:0]         lose_cnt_s;
  logic               pop_s;
  logic               accept_s;
  logic               full_drop_s;
  logic [1:0]         drop_inc_s;
  logic [8:0]         drop_sum_s;
  logic [ENTRY_W-1:0] head_s;
  logic               full_s;
  logic               empty_s;

  // Fixed-priority capture A > R > D; lower-priority pulses in the same cycle are lost.
  always_comb begin
    push_req_s   = 1'b0;
    push_entry_s = '0;
    lose_cnt_s   = 2'd0;
    if (address_ready) begin
      push_req_s   = 1'b1;
      push_entry_s = {TAG_A, address};
      lose_cnt_s   = {1'b0, reg_address_ready} + {1'b0, reg_data_ready};
    end else if (reg_address_ready) begin
      push_req_s   = 1'b1;
      push_entry_s = {TAG_R, reg_address};
      lose_cnt_s   = {1'b0, reg_data_ready};
    end else if (reg_data_ready) begin
      push_req_s   = 1'b1;
      push_entry_s = {TAG_D, reg_data};
      lose_cnt_s   = 2'd0;
    end else begin
      push_req_s   = 1'b0;
      push_entry_s = '0;
      lose_cnt_s   = 2'd0;
    end
  end

  assign pop_s       = (state_r == ST_IDLE) && !empty_s;
  assign accept_s    = push_req_s && (!full_s || pop_s);
  assign full_drop_s = push_req_s && !accept_s;
  assign drop_inc_s  = lose_cnt_s + {1'b0, full_drop_s};
  assign drop_sum_s  = {1'b0, drop_cnt_r} + {7'b0, drop_inc_s};

  event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_event_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .pop_data  (head_s),
    .full      (full_s),
    .empty     (empty_s),
    .level     (fifo_level)
  );

  // Drop accounting; only rst clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_r <= 8'h00;
      overflow_r <= 1'b0;
    end else begin
      if (drop_inc_s != 2'd0) begin
        drop_cnt_r <= drop_sum_s[8] ? 8'hFF : drop_sum_s[7:0];
        overflow_r <= 1'b1;
      end
    end
  end

  // FSM and frame datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      frame_r    <= '0;
      byte_idx_r <= 3'd0;
      tx_data_r  <= 8'h00;
      tx_en_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      frame_r    <= frame_s;
      byte_idx_r <= byte_idx_s;
      tx_data_r  <= tx_data_s;
      tx_en_r    <= tx_en_s;
    end
  end

  // Next-state logic; tx_en is registered so it is high only while in SEND.
  always_comb begin
    state_s    = state_r;
    frame_s    = frame_r;
    byte_idx_s = byte_idx_r;
    tx_data_s  = tx_data_r;
    tx_en_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          frame_s    = head_s;
          byte_idx_s = 3'd0;
          state_s    = ST_LOAD;
        end else begin
          state_s    = ST_IDLE;
        end
      end
      ST_LOAD: begin
        tx_data_s = frame_byte(frame_r, byte_idx_r);
        tx_en_s   = 1'b1;
        state_s   = ST_SEND;
      end
      ST_SEND: begin
        state_s = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (uart_tx_done) begin
          if (byte_idx_r == LAST_IDX) begin
            state_s = ST_IDLE;
          end else begin
            byte_idx_s = byte_idx_r + 3'd1;
            state_s    = ST_LOAD;
          end
        end else begin
          state_s = ST_WAIT_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  assign uart_tx_data = tx_data_r;
  assign uart_tx_en   = tx_en_r;
  assign drop_cnt     = drop_cnt_r;
  assign overflow     = overflow_r;

endmodule
